// File: rtl/dbus_sram_resp_pkg.sv
// rtl/dbus_sram_resp_pkg.sv - dbus request/response types, access sizes and responder state encoding
//
// Contents:
//   msize_t        access size encoding 0..3 (1, 2, 4, 8 bytes)
//   dbus_req_t     request: valid, addr, size, strobe, data
//   dbus_resp_t    response: addr_ok, data_ok, data
//   dresp_state_t  responder state IDLE / WAIT / RESP
//   is_aligned()   natural-alignment test of an address against its size
package dbus_sram_resp_pkg;

    typedef enum logic [1:0] {
        MSIZE1 = 2'd0,
        MSIZE2 = 2'd1,
        MSIZE4 = 2'd2,
        MSIZE8 = 2'd3
    } msize_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
        msize_t      size;
        logic [7:0]  strobe;
        logic [63:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;
    } dbus_resp_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dresp_state_t;

    // Byte accesses are always aligned; wider ones need their low address bits clear.
    function automatic logic is_aligned(input logic [2:0] lsb, input msize_t size);
        logic ok;
        case (size)
            MSIZE1:  ok = 1'b1;
            MSIZE2:  ok = (lsb[0] == 1'b0);
            MSIZE4:  ok = (lsb[1:0] == 2'b00);
            default: ok = (lsb == 3'b000);
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/dbus_sram_bank.sv
// rtl/dbus_sram_bank.sv - single-port DEPTH x 64 SRAM with byte write enables and registered read
//
// Ports:
//   clk    clock
//   en     access enable; when high the word at idx is read into rdata
//   be     per-byte write enable, applied on the same edge as the read
//   idx    word index
//   wdata  write data, already lane-aligned
//   rdata  registered read data (the word as it was before any write on that edge)
module dbus_sram_bank #(
    parameter int DEPTH = 1024
) (
    input  logic                     clk,
    input  logic                     en,
    input  logic [7:0]               be,
    input  logic [$clog2(DEPTH)-1:0] idx,
    input  logic [63:0]              wdata,
    output logic [63:0]              rdata
);

    logic [63:0] mem [DEPTH];

    // No reset: the array and its read register are pure storage.
    always_ff @(posedge clk) begin
        if (en) begin
            rdata <= mem[idx];
            for (int b = 0; b < 8; b++) begin
                if (be[b]) begin
                    mem[idx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/dbus_sram_resp.sv
// rtl/dbus_sram_resp.sv - dbus memory-side responder over an on-chip 64-bit SRAM with wait states
//
// Ports:
//   clk    clock
//   rst    asynchronous active-high reset
//   dreq   request from the memory unit (valid, addr, size, strobe, data)
//   dresp  registered response (addr_ok, data_ok, data)
//   fault  one-cycle pulse with data_ok for a misaligned or out-of-range request
module dbus_sram_resp
    import dbus_sram_resp_pkg::*;
#(
    parameter int          DEPTH   = 1024,
    parameter logic [63:0] BASE    = 64'h8000_0000,
    parameter int          LATENCY = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  dbus_req_t  dreq,
    output dbus_resp_t dresp,
    output logic       fault
);

    localparam int          AW   = $clog2(DEPTH);
    localparam logic [63:0] SPAN = 64'(DEPTH) * 64'd8;

    dresp_state_t state, state_n;
    logic [3:0]   cnt;

    logic [63:0]  addr_q;
    msize_t       size_q;
    logic [7:0]   strb_q;
    logic [63:0]  data_q;

    logic         ok_q;
    logic         fault_q;

    logic [63:0]  cur_addr;
    msize_t       cur_size;
    logic [7:0]   cur_strb;
    logic [63:0]  cur_data;
    logic [63:0]  offset;
    logic         access_ok;

    logic         ok_d;
    logic         fault_d;
    logic         bank_en;
    logic [7:0]   bank_be;
    logic [63:0]  bank_rdata;

    // State register plus the request latch and wait counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= 4'd0;
            addr_q <= '0;
            size_q <= MSIZE1;
            strb_q <= '0;
            data_q <= '0;
        end else begin
            state <= state_n;
            if (state == IDLE && dreq.valid) begin
                addr_q <= dreq.addr;
                size_q <= dreq.size;
                strb_q <= dreq.strobe;
                data_q <= dreq.data;
                cnt    <= 4'(LATENCY);
            end else if (state == WAIT) begin
                cnt <= cnt - 4'd1;
            end
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: if (dreq.valid) state_n = (LATENCY == 0) ? RESP : WAIT;
            WAIT: if (cnt == 4'd1) state_n = RESP;
            RESP: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // With LATENCY=0 the SRAM is accessed on the accept edge itself, before the
    // latch is loaded, so the live request is used while still in IDLE.
    always_comb begin
        cur_addr = addr_q;
        cur_size = size_q;
        cur_strb = strb_q;
        cur_data = data_q;
        if (state == IDLE) begin
            cur_addr = dreq.addr;
            cur_size = dreq.size;
            cur_strb = dreq.strobe;
            cur_data = dreq.data;
        end
    end

    // The offset is checked at full width; only a passing address gets truncated to an index.
    assign offset    = cur_addr - BASE;
    assign access_ok = (cur_addr >= BASE) && (offset < SPAN) && is_aligned(cur_addr[2:0], cur_size);

    // Next values of the registered outputs and the SRAM controls, all keyed on entering RESP.
    always_comb begin
        ok_d    = (state_n == RESP);
        fault_d = (state_n == RESP) && !access_ok;
        bank_en = (state_n == RESP) && access_ok;
        bank_be = bank_en ? cur_strb : 8'h00;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ok_q    <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            ok_q    <= ok_d;
            fault_q <= fault_d;
        end
    end

    dbus_sram_bank #(
        .DEPTH (DEPTH)
    ) u_bank (
        .clk   (clk),
        .en    (bank_en),
        .be    (bank_be),
        .idx   (offset[AW+2:3]),
        .wdata (cur_data),
        .rdata (bank_rdata)
    );

    // The bank's read register is not reset and is not reloaded on a faulting
    // access, so its value is only exposed during a good response.
    assign dresp.addr_ok = ok_q;
    assign dresp.data_ok = ok_q;
    assign dresp.data    = (ok_q && !fault_q) ? bank_rdata : 64'h0;
    assign fault         = fault_q;

endmodule

// File: doc/dbus_sram_resp.md
Name: dbus_sram_resp

Overview:
- Data-bus responder: the memory side of the dbus handshake that the memory unit initiates.
- Accepts one dbus_req_t at a time.
- Performs a byte-strobed write or a full-word read on an internal 64-bit-wide SRAM after a programmable number of wait states.
- Returns dbus_resp_t with a one-cycle data_ok pulse.
- Used as the data-memory model in core-level simulation and as the on-chip scratchpad behind the dbus.

Parameters:
- DEPTH, 1024, number of 64-bit words (power of two).
- BASE, 64'h8000_0000, byte address of word 0.
- LATENCY, 2, wait cycles between accept and response (0..15).

Ports:
- clk  input  1  clock.
- rst  input  1  reset. One clock; reset is asynchronous and active-high.
- dreq  input  dbus_req_t  request: valid, addr, size, strobe, data.
- dresp  output  dbus_resp_t  response: addr_ok, data_ok, data.
- fault  output  1  one-cycle pulse, coincident with data_ok, for a misaligned or out-of-range request.

Behaviour:
- Reset values: state=IDLE, wait counter 0, dresp.addr_ok=0, dresp.data_ok=0, dresp.data=0, fault=0. SRAM contents are not reset.
- All outputs are registered.
- States: IDLE, WAIT, RESP.
- IDLE:
  - If dreq.valid=1, latch addr, size, strobe and data into internal registers (accept edge).
  - Load counter=LATENCY.
  - Go to WAIT, or directly to RESP when LATENCY=0.
  - dreq is ignored in every other state. Later changes to the request fields have no effect.
- WAIT: decrement the counter each cycle. When the counter reaches 1, the next state is RESP. With an accept at edge T, data_ok is high during cycle T+1+LATENCY.
- SRAM access happens on the edge entering RESP.
  - Word index = (addr-BASE)>>3.
  - Write when strobe≠0: for each bit i with strobe[i]=1, word byte i ← data byte i. Other bytes are unchanged. data arrives already lane-shifted by the requester.
  - Read when strobe=0: dresp.data ← full 64-bit word. The requester extracts lanes and sign-extends. On a write, dresp.data = the pre-write word.
- RESP:
  - Exactly one cycle with addr_ok=1 and data_ok=1.
  - Next state is IDLE unconditionally.
  - The requester's valid is still high in this cycle; because the state is RESP, it is not re-accepted.
  - A new request can be accepted in the following IDLE cycle.
  - Maximum throughput is one request per LATENCY+2 cycles.
- Range check: addr<BASE or addr≥BASE+8*DEPTH. The read returns data=0, the write is dropped, fault=1 in RESP.
- Alignment check: size 1 needs addr[0]=0, size 2 needs addr[1:0]=0, size 3 needs addr[2:0]=0.
  - On violation, fault=1 and the access is suppressed: read data=0, write dropped.
  - size 0 is always aligned.
- Strobe/size consistency is not checked. The strobe is authoritative for writes.
- Reset asserted mid-operation: immediately IDLE, outputs 0, any pending write discarded. A write already committed to the SRAM stays.
- Arithmetic: address offset is computed in 64 bits; the index is truncated to $clog2(DEPTH) bits only after the range check passes.

Decomposition:
- Shared package (common): dbus_req_t, dbus_resp_t, msize_t encodings 0..3 (already present), and a new enum dresp_state_t {IDLE, WAIT, RESP}.
- One sub-module: dbus_sram_bank.
  - Synchronous single-port DEPTH×64 array with a per-byte write enable (8-bit) and registered read data.
  - Write and read happen on the same edge; read returns old data.
  - No reset on the array.

Test Plan:
- LATENCY=2, write addr=0x8000_0010, strobe=0xFF, data=0x1122334455667788; accept at edge T.
  - data_ok is high only in cycle T+3, fault=0.
  - A follow-up read of the same address returns 0x1122334455667788.
- Byte-lane merge: word 0x8000_0008 holds 0xFFFFFFFFFFFFFFFF; write strobe=0x04, data=0x0000000000AB0000, size 0, addr 0x8000_000A.
  - Read back gives 0xFFFFFFFFFFABFFFF.
- Valid held high through RESP and into the next cycle.
  - Only two accepts occur: the second starts at the first IDLE after RESP.
  - data_ok pulses are exactly LATENCY+2 cycles apart.
- Misaligned read (size 2, addr 0x8000_0006) and out-of-range write (addr 0x7FFF_FFF8).
  - Each gives fault=1 with data_ok and data=0; memory is unchanged.
- LATENCY=0: accept at edge T gives data_ok in cycle T+1. Back-to-back reads of 0x8000_0000 and 0x8000_0008 return the correct words.
- Assert rst during WAIT of a write to 0x8000_0020.
  - Outputs are 0 immediately; no data_ok.
  - The word at 0x8000_0020 keeps its prior value; the next request completes normally.
